aurora_tx_axis_16to32: RTL

- 16-bit to 32-bit AXI4-Stream upsizer on the Aurora transmit path.
- Sits directly upstream of the 8b10b core wrapper's 32-bit s_axis_tx port, in the user_clk domain.
- Packs pairs of 16-bit beats into one 32-bit word, first beat in the upper lanes.
- Handles odd-length packets and backpressure, flags protocol violations, and counts emitted packets.

---
 rtl/aurora_axis_pkg.sv | 17 +
 rtl/aurora_tx_axis_16to32.sv | 115 +++++++++++
 2 files changed

// File: rtl/aurora_axis_pkg.sv
// Shared encodings for the Aurora transmit-path AXI4-Stream width converters.
package aurora_axis_pkg;

    // Packer state: whether an upper half-word is being held.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } tx_state_e;

    localparam logic [1:0] KEEP16_FULL = 2'b11;
    localparam logic [1:0] KEEP16_HI   = 2'b10;
    localparam logic [3:0] KEEP32_FULL = 4'b1111;
    localparam logic [3:0] KEEP32_HI   = 4'b1100;

    localparam int unsigned PKT_CNT_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/aurora_tx_axis_16to32.sv
// 16-bit to 32-bit AXI4-Stream upsizer feeding the 8b10b core wrapper's s_axis_tx port.
// Pairs of 16-bit beats pack into one 32-bit word, first beat in the upper lanes.
// Odd-length packets emit a half-filled last word; illegal tkeep patterns raise a
// sticky protocol_err; pkt_count tracks m-side tlast transfers.
module aurora_tx_axis_16to32
    import aurora_axis_pkg::*;
#(
    parameter int unsigned PKT_CNT_WIDTH = PKT_CNT_WIDTH_DEFAULT
) (
    input  logic                     user_clk,
    input  logic                     aresetn,
    input  logic [0:15]              s_axis_tdata,
    input  logic [0:1]               s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [0:31]              m_axis_tdata,
    output logic [0:3]               m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic                     protocol_err,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count
);

    localparam logic [PKT_CNT_WIDTH-1:0] CNT_ONE = {{(PKT_CNT_WIDTH-1){1'b0}}, 1'b1};

    tx_state_e   state;
    logic [15:0] hold_data;
    logic [1:0]  hold_keep;

    logic        slot_free;
    logic        beat;
    logic        beat_used;
    logic        beat_illegal;
    logic [1:0]  keep_eff;

    // A slot is free when it is empty or draining this cycle, so it can reload without a bubble.
    assign slot_free = !m_axis_tvalid || m_axis_tready;

    // Only a beat that completes a word needs the slot; a first half-word can always be held.
    assign s_axis_tready = aresetn && (slot_free || (state == ST_EMPTY && !s_axis_tlast));

    assign beat      = s_axis_tvalid && s_axis_tready;
    // tkeep=00 beats are swallowed without touching state, tlast included.
    assign beat_used = beat && (s_axis_tkeep != 2'b00);

    // Normalise tkeep: only a tlast beat may be half-filled; other bad patterns count as full.
    always_comb begin
        keep_eff     = KEEP16_FULL;
        beat_illegal = 1'b0;
        case (s_axis_tkeep)
            KEEP16_FULL: keep_eff = KEEP16_FULL;
            KEEP16_HI: begin
                if (s_axis_tlast) begin
                    keep_eff = KEEP16_HI;
                end else begin
                    beat_illegal = 1'b1;
                end
            end
            2'b01:   beat_illegal = 1'b1;
            default: begin
                keep_eff     = 2'b00;
                beat_illegal = 1'b1;
            end
        endcase
    end

    // Packer FSM, hold register, registered output slot, error flag and packet counter.
    always_ff @(posedge user_clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_EMPTY;
            hold_data     <= 16'h0000;
            hold_keep     <= 2'b00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= 32'h0000_0000;
            m_axis_tkeep  <= 4'b0000;
            protocol_err  <= 1'b0;
            pkt_count     <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                if (m_axis_tlast) begin
                    pkt_count <= pkt_count + CNT_ONE;
                end
            end

            if (beat && beat_illegal) begin
                protocol_err <= 1'b1;
            end

            if (beat_used) begin
                if (state == ST_HALF) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= {hold_data, s_axis_tdata};
                    m_axis_tkeep  <= {hold_keep, keep_eff};
                    m_axis_tlast  <= s_axis_tlast;
                    state         <= ST_EMPTY;
                end else if (s_axis_tlast) begin
                    // Single half-word at end of packet: upper lanes only.
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= {s_axis_tdata, 16'h0000};
                    m_axis_tkeep  <= {keep_eff, 2'b00};
                    m_axis_tlast  <= 1'b1;
                end else begin
                    hold_data <= s_axis_tdata;
                    hold_keep <= keep_eff;
                    state     <= ST_HALF;
                end
            end
        end
    end

endmodule
